// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS boot loader.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CHECK,
    RUN,
    ERROR
  } boot_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/mips_boot_loader_word_assembler.sv
// Packs four big-endian bytes into a 32-bit word; word_full marks a complete word.
module boot_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [1:0]  o_idx,
  output logic        o_word_full
);

  logic [31:0] r_word;
  logic [1:0]  r_idx;
  logic        r_full;

  // Index wraps 3 -> 0 on its own, so a new word always starts at byte 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word <= 32'h0;
      r_idx  <= 2'd0;
      r_full <= 1'b0;
    end else if (i_clr) begin
      r_word <= 32'h0;
      r_idx  <= 2'd0;
      r_full <= 1'b0;
    end else if (i_shift) begin
      r_word <= {r_word[23:0], i_byte};
      r_idx  <= r_idx + 2'd1;
      r_full <= (r_idx == 2'd3);
    end
  end

  assign o_word      = r_word;
  assign o_idx       = r_idx;
  assign o_word_full = r_full;

endmodule

// File: rtl/mips_boot_loader.sv
// Holds the MIPS core in reset, loads a checksummed byte-stream image into memory,
// then releases the core and passes its bus straight through to memory.
module mips_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        cpu_reset,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_writedata,
  input  logic        cpu_memwrite,
  output logic [31:0] cpu_readdata,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_writedata,
  output logic        mem_memwrite,
  input  logic [31:0] mem_readdata,
  output logic        loading,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  localparam logic [31:0] MAX_WORDS = 32'(MEM_WORDS) - (BASE_ADDR >> 2);

  boot_state_t r_state;
  logic [15:0] r_len;
  logic [15:0] r_words;
  logic [7:0]  r_csum;
  logic [31:0] r_addr;
  logic        r_cpu_reset;
  logic        r_done;
  logic        r_err;

  logic        w_accept;
  logic        w_sync;
  logic        w_shift;
  logic [15:0] w_len;
  logic [15:0] w_words_nxt;
  logic [31:0] w_word;
  logic [1:0]  w_idx;
  logic        w_word_full;

  assign rx_ready    = (r_state != WRITE);
  assign w_accept    = rx_valid & rx_ready;
  assign w_sync      = w_accept && (rx_data == SYNC_BYTE) &&
                       ((r_state == IDLE) || (r_state == ERROR));
  assign w_shift     = w_accept && (r_state == DATA);
  assign w_len       = {r_len[15:8], rx_data};
  assign w_words_nxt = r_words + 16'd1;

  boot_word_assembler u_asm (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_sync),
    .i_shift     (w_shift),
    .i_byte      (rx_data),
    .o_word      (w_word),
    .o_idx       (w_idx),
    .o_word_full (w_word_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_len       <= 16'h0;
      r_words     <= 16'h0;
      r_csum      <= 8'h0;
      r_addr      <= BASE_ADDR;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ERROR: begin
          // A sync byte in ERROR restarts the whole load from BASE_ADDR.
          if (w_sync) begin
            r_state <= LEN_HI;
            r_err   <= 1'b0;
            r_words <= 16'h0;
            r_csum  <= 8'h0;
            r_addr  <= BASE_ADDR;
          end
        end
        LEN_HI: begin
          if (w_accept) begin
            r_len[15:8] <= rx_data;
            r_state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (w_accept) begin
            r_len[7:0] <= rx_data;
            if (w_len == 16'h0) begin
              r_state <= CHECK;
            end else if ({16'h0, w_len} > MAX_WORDS) begin
              r_state <= ERROR;
              r_err   <= 1'b1;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_accept) begin
            r_csum <= r_csum + rx_data;
            if (w_idx == 2'd3) r_state <= WRITE;
          end
        end
        WRITE: begin
          r_addr  <= r_addr + 32'd4;
          r_words <= w_words_nxt;
          r_state <= (w_words_nxt == r_len) ? CHECK : DATA;
        end
        CHECK: begin
          if (w_accept) begin
            if (rx_data == r_csum) begin
              r_state     <= RUN;
              r_cpu_reset <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_state <= ERROR;
              r_err   <= 1'b1;
            end
          end
        end
        RUN: r_state <= RUN;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_adr       = r_addr;
    mem_writedata = w_word;
    mem_memwrite  = (r_state == WRITE) && w_word_full;
    if (r_state == RUN) begin
      mem_adr       = cpu_adr;
      mem_writedata = cpu_writedata;
      mem_memwrite  = cpu_memwrite;
    end
  end

  assign cpu_readdata = mem_readdata;
  assign loading      = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                        (r_state == DATA)   || (r_state == WRITE)  ||
                        (r_state == CHECK);
  assign cpu_reset    = r_cpu_reset;
  assign done         = r_done;
  assign err          = r_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed bench: frames built from word images, expected writes/outcome predicted per frame.
module tb_mips_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_ready;
  logic        cpu_reset;
  logic [31:0] cpu_adr = 32'h0;
  logic [31:0] cpu_writedata = 32'h0;
  logic        cpu_memwrite = 1'b0;
  logic [31:0] cpu_readdata;
  logic [31:0] mem_adr;
  logic [31:0] mem_writedata;
  logic        mem_memwrite;
  logic [31:0] mem_readdata;
  logic        loading;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  mips_boot_loader dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .cpu_reset(cpu_reset), .cpu_adr(cpu_adr), .cpu_writedata(cpu_writedata),
    .cpu_memwrite(cpu_memwrite), .cpu_readdata(cpu_readdata), .mem_adr(mem_adr),
    .mem_writedata(mem_writedata), .mem_memwrite(mem_memwrite), .mem_readdata(mem_readdata),
    .loading(loading), .done(done), .err(err), .words_loaded(words_loaded)
  );

  logic [31:0] mem [64];
  assign mem_readdata = mem[mem_adr[7:2]];
  always @(posedge clk) if (mem_memwrite) mem[mem_adr[7:2]] <= mem_writedata;

  int n_err = 0;
  int n_chk = 0;
  int n_wr = 0;
  int stalls = 0;
  int accepted = 0;

  logic [7:0]  tx_q [$];
  logic [31:0] exp_wr_a [$];
  logic [31:0] exp_wr_d [$];
  logic [31:0] img [70];
  logic [31:0] exp_mem [64];
  logic        exp_done;
  logic        exp_err;
  logic [15:0] exp_words;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Loader writes must arrive in order at the predicted address/data; stalls only on writes.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_memwrite && !done) begin
        n_wr++;
        if (exp_wr_a.size() == 0) begin
          chk("unexpected_write_adr", mem_adr, 32'hFFFF_FFFF);
        end else begin
          chk("write_adr", mem_adr, exp_wr_a.pop_front());
          chk("write_dat", mem_writedata, exp_wr_d.pop_front());
        end
      end
      chk("rx_ready", {31'h0, rx_ready}, {31'h0, !(mem_memwrite && !done)});
    end
  end

  // Builds the byte stream for an n-word image and predicts the load outcome.
  task automatic make_frame(input int n, input bit bad);
    logic [7:0] cs;
    cs = 8'h0;
    tx_q.delete();
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'(n >> 8));
    tx_q.push_back(8'(n));
    if (n > 64) begin
      exp_done = 1'b0; exp_err = 1'b1; exp_words = 16'h0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      for (int b = 3; b >= 0; b--) begin
        tx_q.push_back(img[i][8*b +: 8]);
        cs = cs + img[i][8*b +: 8];
      end
      exp_wr_a.push_back(32'(i * 4));
      exp_wr_d.push_back(img[i]);
      exp_mem[i] = img[i];
    end
    tx_q.push_back(bad ? cs + 8'h1 : cs);
    exp_done = !bad; exp_err = bad; exp_words = 16'(n);
  endtask

  task automatic send_tx();
    int g;
    while (tx_q.size() > 0) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = tx_q.pop_front();
      g = 0;
      while (!rx_ready && g < 8) begin
        @(negedge clk);
        g++;
        stalls++;
      end
      if (g >= 8) chk("rx_ready_timeout", 32'h0, 32'h1);
      accepted++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int n);
    @(negedge clk);
    chk({tag, "_done"}, {31'h0, done}, {31'h0, exp_done});
    chk({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
    chk({tag, "_cpu_reset"}, {31'h0, cpu_reset}, {31'h0, !exp_done});
    chk({tag, "_words"}, {16'h0, words_loaded}, {16'h0, exp_words});
    chk({tag, "_loading"}, {31'h0, loading}, 32'h0);
    chk({tag, "_pending_writes"}, 32'(exp_wr_a.size()), 32'h0);
    for (int i = 0; i < n && i < 64; i++) chk({tag, "_mem"}, mem[i], exp_mem[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rx_valid = 1'b0; cpu_memwrite = 1'b0;
    exp_wr_a.delete(); exp_wr_d.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    for (int i = 0; i < 64; i++) begin mem[i] = 32'h0; exp_mem[i] = 32'h0; end
    do_reset();

    // Reset state
    chk("rst_cpu_reset", {31'h0, cpu_reset}, 32'h1);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_loading", {31'h0, loading}, 32'h0);
    chk("rst_words", {16'h0, words_loaded}, 32'h0);
    chk("rst_mem_memwrite", {31'h0, mem_memwrite}, 32'h0);

    // Test 1: single word
    img[0] = 32'h12345678;
    make_frame(1, 1'b0);
    chk("t1_csum_literal", {24'h0, tx_q[$]}, 32'h14);
    send_tx();
    check_frame("t1", 1);
    chk("t1_mem0_literal", mem[0], 32'h12345678);

    // Test 2: two words then a core store passes through
    do_reset();
    img[0] = 32'h8C010004; img[1] = 32'hAC010008;
    make_frame(2, 1'b0);
    chk("t2_csum_literal", {24'h0, tx_q[$]}, 32'h46);
    send_tx();
    check_frame("t2", 2);
    cpu_adr = 32'h8; cpu_writedata = 32'hDEADBEEF; cpu_memwrite = 1'b1;
    #1;
    chk("t2_pass_adr", mem_adr, 32'h8);
    chk("t2_pass_dat", mem_writedata, 32'hDEADBEEF);
    chk("t2_pass_we", {31'h0, mem_memwrite}, 32'h1);
    @(negedge clk);
    cpu_memwrite = 1'b0; cpu_adr = 32'h4;
    #1;
    chk("t2_store_landed", mem[2], 32'hDEADBEEF);
    chk("t2_readdata", cpu_readdata, 32'hAC010008);

    // Test 3: bad checksum, core stores ignored in ERROR, then good resend
    do_reset();
    img[0] = 32'h12345678;
    make_frame(1, 1'b1);
    chk("t3_bad_csum_literal", {24'h0, tx_q[$]}, 32'h15);
    send_tx();
    check_frame("t3_bad", 1);
    cpu_memwrite = 1'b1; cpu_adr = 32'h10;
    #1;
    chk("t3_err_blocks_cpu_we", {31'h0, mem_memwrite}, 32'h0);
    cpu_memwrite = 1'b0;
    make_frame(1, 1'b0);
    send_tx();
    check_frame("t3_good", 1);

    // Test 4: empty image, then oversize length
    do_reset();
    w0 = n_wr;
    make_frame(0, 1'b0);
    chk("t4_len0_bytes", 32'(tx_q.size()), 32'd4);
    send_tx();
    check_frame("t4_empty", 0);
    chk("t4_empty_nowrite", 32'(n_wr - w0), 32'h0);
    do_reset();
    make_frame(65, 1'b0);
    send_tx();
    check_frame("t4_oversize", 0);
    chk("t4_oversize_nowrite", 32'(n_wr - w0), 32'h0);

    // Test 5: back-to-back stream, stalls only on writes
    do_reset();
    for (int i = 0; i < 5; i++) img[i] = $urandom;
    make_frame(5, 1'b0);
    stalls = 0; accepted = 0;
    send_tx();
    check_frame("t5", 5);
    chk("t5_stalls", 32'(stalls), 32'd5);
    chk("t5_accepted", 32'(accepted), 32'd24);

    // Test 6: reset after 2nd data byte, then a full load
    do_reset();
    w0 = n_wr;
    tx_q.delete();
    tx_q.push_back(8'hA5); tx_q.push_back(8'h00); tx_q.push_back(8'h01);
    tx_q.push_back(8'h12); tx_q.push_back(8'h34);
    send_tx();
    chk("t6_mid_loading", {31'h0, loading}, 32'h1);
    do_reset();
    chk("t6_cpu_reset", {31'h0, cpu_reset}, 32'h1);
    chk("t6_loading", {31'h0, loading}, 32'h0);
    chk("t6_nowrite", 32'(n_wr - w0), 32'h0);
    img[0] = 32'hCAFEF00D; img[1] = 32'h00A5A500; img[2] = 32'hFFFFFFFF;
    make_frame(3, 1'b0);
    send_tx();
    check_frame("t6", 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
